// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: synchronized edge capture, per-bit mask, arbitrated level IRQ.
// Define IRQC_ROUND_ROBIN_EN for rotating priority; the default build uses fixed lowest-index priority.
`timescale 1ns/1ps
module irq_controller #(
    parameter int          NUM_SRC   = 16,
    parameter logic [15:0] BASE_ADDR = 16'hF000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src,
    input  logic [15:0]        addr,
    input  logic [7:0]         din,
    input  logic               read_en,
    output logic [7:0]         dout,
    output logic               sel,
    output logic               irq
);

    typedef enum logic [2:0] {
        OFF_MASK_LO = 3'd0,
        OFF_MASK_HI = 3'd1,
        OFF_PEND_LO = 3'd2,
        OFF_PEND_HI = 3'd3,
        OFF_VECTOR  = 3'd4,
        OFF_SWSET   = 3'd5,
        OFF_CLRALL  = 3'd6
    } reg_off_e;

    // Bits above NUM_SRC are held at zero so they read 0 and ignore writes.
    localparam logic [15:0] SRC_VALID = 16'((17'd1 << NUM_SRC) - 17'd1);

    logic [NUM_SRC-1:0] sync1, sync2, prev;
    logic [15:0]        mask_q, pending_q, pending_d;
    logic [15:0]        rise, active, idx_vec, set_vec, clr_vec;
    logic [15:0]        offset;
    reg_off_e           reg_off;
    logic               wr;
    logic [3:0]         winner;
    logic               valid;
    logic [7:0]         vector;

    // Unsigned wrap makes addresses below BASE_ADDR land far outside the window.
    assign offset  = addr - BASE_ADDR;
    assign sel     = offset < 16'd7;
    assign reg_off = reg_off_e'(offset[2:0]);
    assign wr      = sel && !read_en;

    assign rise    = 16'(sync2 & ~prev);
    assign idx_vec = (16'h0001 << din[3:0]) & SRC_VALID;
    assign set_vec = rise | ((wr && reg_off == OFF_SWSET) ? idx_vec : 16'h0000);
    assign clr_vec = (wr && reg_off == OFF_CLRALL) ? 16'hFFFF :
                     (wr && reg_off == OFF_VECTOR) ? idx_vec  : 16'h0000;
    // Set is applied after clear so a same-cycle edge or SWSET keeps the bit pending.
    assign pending_d = ((pending_q & ~clr_vec) | set_vec) & SRC_VALID;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            prev      <= '0;
            mask_q    <= '0;
            pending_q <= '0;
        end else begin
            sync1     <= src;
            sync2     <= sync1;
            prev      <= sync2;
            pending_q <= pending_d;
            if (wr && reg_off == OFF_MASK_LO) mask_q[7:0]  <= din & SRC_VALID[7:0];
            if (wr && reg_off == OFF_MASK_HI) mask_q[15:8] <= din & SRC_VALID[15:8];
        end
    end

    assign active = pending_q & mask_q;
    assign valid  = |active;
    assign irq    = valid;

`ifdef IRQC_ROUND_ROBIN_EN
    logic [3:0] rr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= '0;
        end else if (wr && reg_off == OFF_VECTOR && |idx_vec) begin
            rr_q <= (din[3:0] == 4'(NUM_SRC - 1)) ? 4'd0 : din[3:0] + 4'd1;
        end
    end

    // Scan downward so the last hit is the first active index at or above rr_q.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[(int'(rr_q) + i) % NUM_SRC]) winner = 4'((int'(rr_q) + i) % NUM_SRC);
        end
    end
`else
    // NOTE: combinational outputs get a default first so no path infers a latch.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) winner = 4'(i);
        end
    end
`endif

    assign vector = valid ? {4'h8, winner} : 8'h00;

    always_comb begin
        dout = 8'h00;
        if (sel) begin
            case (reg_off)
                OFF_MASK_LO: dout = mask_q[7:0];
                OFF_MASK_HI: dout = mask_q[15:8];
                OFF_PEND_LO: dout = pending_q[7:0];
                OFF_PEND_HI: dout = pending_q[15:8];
                OFF_VECTOR:  dout = vector;
                default:     dout = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller (fixed-priority build): directed steps, then random
// traffic against a per-edge behavioural model of two instances (16 sources and 8 sources).
`timescale 1ns/1ps
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] src0;
    logic [7:0]  src1;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        read_en;
    logic [7:0]  dout0, dout1;
    logic        sel0, sel1, irq0, irq1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    irq_controller #(.NUM_SRC(16), .BASE_ADDR(16'hF000)) dut0 (
        .clk(clk), .reset(reset), .src(src0), .addr(addr), .din(din),
        .read_en(read_en), .dout(dout0), .sel(sel0), .irq(irq0)
    );

    irq_controller #(.NUM_SRC(8), .BASE_ADDR(16'h8000)) dut1 (
        .clk(clk), .reset(reset), .src(src1), .addr(addr), .din(din),
        .read_en(read_en), .dout(dout1), .sel(sel1), .irq(irq1)
    );

    // Model: per instance, pending/mask words and the raw src value seen at the last three edges.
    int          m_n    [2] = '{16, 8};
    logic [15:0] m_base [2] = '{16'hF000, 16'h8000};
    logic [15:0] m_mask [2];
    logic [15:0] m_pend [2];
    logic [15:0] m_samp [2][3];

    function automatic logic [15:0] valid_bits(int k);
        return 16'((32'd1 << m_n[k]) - 32'd1);
    endfunction

    function automatic logic [15:0] cur_src(int k);
        return (k == 0) ? src0 : {8'h00, src1};
    endfunction

    function automatic logic m_sel(int k, logic [15:0] a);
        return int'(a) >= int'(m_base[k]) && int'(a) <= int'(m_base[k]) + 6;
    endfunction

    function automatic logic m_irq(int k);
        return (m_pend[k] & m_mask[k]) != 16'h0000;
    endfunction

    function automatic logic [7:0] m_read(int k, logic [15:0] a);
        int off;
        logic [15:0] act;
        if (!m_sel(k, a)) return 8'h00;
        off = int'(a) - int'(m_base[k]);
        act = m_pend[k] & m_mask[k];
        case (off)
            0: return m_mask[k][7:0];
            1: return m_mask[k][15:8];
            2: return m_pend[k][7:0];
            3: return m_pend[k][15:8];
            4: begin
                for (int i = 0; i < m_n[k]; i++)
                    if (act[i]) return 8'h80 | 8'(i);
                return 8'h00;
            end
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mask[k] = '0;
            m_pend[k] = '0;
            for (int j = 0; j < 3; j++) m_samp[k][j] = '0;
        end
    endtask

    // One clock edge: a raw src rise seen two edges ago pends now; bus writes act at this edge.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic [15:0] setb, clrb, newmask;
            int idx, off;
            setb    = m_samp[k][1] & ~m_samp[k][2];
            clrb    = '0;
            newmask = m_mask[k];
            idx     = int'(din[3:0]);
            if (!read_en && m_sel(k, addr)) begin
                off = int'(addr) - int'(m_base[k]);
                case (off)
                    0: newmask = {m_mask[k][15:8], din};
                    1: newmask = {din, m_mask[k][7:0]};
                    4: if (idx < m_n[k]) clrb[idx] = 1'b1;
                    5: if (idx < m_n[k]) setb[idx] = 1'b1;
                    6: clrb = 16'hFFFF;
                    default: ;
                endcase
            end
            m_mask[k] = newmask & valid_bits(k);
            m_pend[k] = ((m_pend[k] & ~clrb) | setb) & valid_bits(k);
            m_samp[k][2] = m_samp[k][1];
            m_samp[k][1] = m_samp[k][0];
            m_samp[k][0] = cur_src(k);
        end
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("irq0", 16'(irq0), 16'(m_irq(0)));
        check("irq1", 16'(irq1), 16'(m_irq(1)));
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        addr    = a;
        din     = d;
        read_en = 1'b0;
        tick();
        read_en = 1'b1;
        addr    = 16'h0000;
    endtask

    task automatic expect_rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
        addr    = a;
        read_en = 1'b1;
        #1;
        check(tag, 16'((a[15:12] == 4'hF) ? dout0 : dout1), 16'(exp));
    endtask

    task automatic pulse0(input logic [15:0] bits);
        src0 = bits;
        tick();
        src0 = '0;
        tick();
        tick();
    endtask

    initial begin
        reset   = 1'b1;
        src0    = '0;
        src1    = '0;
        addr    = 16'h0000;
        din     = 8'h00;
        read_en = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state and address window decode
        check("rst_irq0", 16'(irq0), 16'h0000);
        check("rst_irq1", 16'(irq1), 16'h0000);
        for (int o = 0; o < 7; o++) expect_rd("rst_reg", 16'hF000 + 16'(o), 8'h00);
        addr = 16'hF006; #1; check("sel_top", 16'(sel0), 16'h0001);
        addr = 16'hF007; #1; check("sel_past", 16'(sel0), 16'h0000);
        addr = 16'hEFFF; #1; check("sel_below", 16'(sel0), 16'h0000);
        addr = 16'h8006; #1; check("sel1_top", 16'(sel1), 16'h0001);

        // Basic: mask bit 0, pulse src[0], irq on the third edge, ack clears
        bus_write(16'hF000, 8'h01);
        src0 = 16'h0001;
        tick();
        src0 = '0;
        tick();
        check("lat_e1", 16'(irq0), 16'h0000);
        tick();
        check("lat_e2", 16'(irq0), 16'h0001);
        expect_rd("pend_s0", 16'hF002, 8'h01);
        expect_rd("vec_s0", 16'hF004, 8'h80);
        bus_write(16'hF004, 8'h00);
        check("ack_irq", 16'(irq0), 16'h0000);
        expect_rd("pend_ack", 16'hF002, 8'h00);

        // Masked source still pends; unmasking raises irq at the write edge
        bus_write(16'hF000, 8'h00);
        pulse0(16'h0008);
        expect_rd("pend_masked", 16'hF002, 8'h08);
        check("irq_masked", 16'(irq0), 16'h0000);
        bus_write(16'hF000, 8'h08);
        check("irq_unmask", 16'(irq0), 16'h0001);
        expect_rd("vec_s3", 16'hF004, 8'h83);
        bus_write(16'hF004, 8'h03);

        // Fixed priority between sources 5 and 12
        bus_write(16'hF000, 8'hFF);
        bus_write(16'hF001, 8'hFF);
        pulse0(16'h1020);
        expect_rd("vec_5", 16'hF004, 8'h85);
        bus_write(16'hF004, 8'h05);
        expect_rd("vec_12", 16'hF004, 8'h8C);
        bus_write(16'hF004, 8'h0C);
        check("prio_done", 16'(irq0), 16'h0000);

        // Edge lands on the same edge as an ack of that bit: set wins
        bus_write(16'hF005, 8'h01);
        src0 = 16'h0002;
        tick();
        tick();
        bus_write(16'hF004, 8'h01);
        expect_rd("set_vs_ack", 16'hF002, 8'h02);
        check("set_vs_ack_irq", 16'(irq0), 16'h0001);
        src0 = '0;
        bus_write(16'hF004, 8'h01);
        expect_rd("ack1", 16'hF002, 8'h00);

        // Edge versus CLRALL on the same edge
        src0 = 16'h0004;
        tick();
        tick();
        bus_write(16'hF006, 8'h00);
        expect_rd("set_vs_clr", 16'hF002, 8'h04);
        src0 = '0;
        bus_write(16'hF006, 8'h5A);
        expect_rd("clrall", 16'hF002, 8'h00);

        // Top index on the 16-source instance
        bus_write(16'hF005, 8'h0F);
        expect_rd("pend_hi15", 16'hF003, 8'h80);
        bus_write(16'hF004, 8'h1F);
        expect_rd("ack15", 16'hF003, 8'h00);

        // 8-source instance: out-of-range indices and upper bits are ignored
        bus_write(16'h8005, 8'h03);
        bus_write(16'h8004, 8'h0A);
        expect_rd("n8_ack_oob", 16'h8002, 8'h08);
        bus_write(16'h8005, 8'h0B);
        expect_rd("n8_sw_oob", 16'h8002, 8'h08);
        bus_write(16'h8001, 8'hFF);
        expect_rd("n8_mask_hi", 16'h8001, 8'h00);
        expect_rd("n8_pend_hi", 16'h8003, 8'h00);
        bus_write(16'h8000, 8'h08);
        check("n8_irq", 16'(irq1), 16'h0001);
        expect_rd("n8_vec", 16'h8004, 8'h83);
        bus_write(16'h8006, 8'h00);

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            int k;
            k       = int'($urandom_range(1, 0));
            src0    = 16'($urandom & $urandom & $urandom);
            src1    = 8'($urandom & $urandom & $urandom);
            addr    = m_base[k] + 16'($urandom_range(7, 0));
            din     = 8'($urandom);
            read_en = ($urandom_range(2, 0) != 0);
            #1;
            check("rnd_dout0", 16'(dout0), 16'(m_read(0, addr)));
            check("rnd_dout1", 16'(dout1), 16'(m_read(1, addr)));
            check("rnd_sel0", 16'(sel0), 16'(m_sel(0, addr)));
            check("rnd_sel1", 16'(sel1), 16'(m_sel(1, addr)));
            tick();
        end
        src0    = '0;
        src1    = '0;
        read_en = 1'b1;

        // Asynchronous reset mid-operation with both irqs active
        bus_write(16'hF000, 8'hFF);
        bus_write(16'hF005, 8'h04);
        bus_write(16'h8000, 8'hFF);
        bus_write(16'h8005, 8'h02);
        check("pre_rst_irq0", 16'(irq0), 16'h0001);
        check("pre_rst_irq1", 16'(irq1), 16'h0001);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_irq0", 16'(irq0), 16'h0000);
        check("async_irq1", 16'(irq1), 16'h0000);
        for (int o = 0; o < 7; o++) begin
            expect_rd("rst_dut0", 16'hF000 + 16'(o), 8'h00);
            expect_rd("rst_dut1", 16'h8000 + 16'(o), 8'h00);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        expect_rd("post_rst_mask", 16'hF000, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Memory-mapped interrupt controller sitting between the 16 pushbutton sources and the 8227 core's `interruptRequest` input, replacing the single OR-and-edge-detect path. Each source is synchronized, rising-edge detected, latched as pending, masked per bit, and arbitrated into one level-sensitive IRQ line. The core reads a vector register to learn which source is being serviced, and writes it to acknowledge that source.

## Interface
- `NUM_SRC`, 16: number of interrupt sources, 1..16. Unused upper bits read 0 and ignore writes.
- `BASE_ADDR`, 16'hF000: address of the first of 7 registers (BASE..BASE+6).
- `clk` in 1: system clock; one clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `src` in NUM_SRC: raw asynchronous request inputs (pb[15:0]).
- `addr` in 16: CPU address bus {addressBusHigh, addressBusLow}.
- `din` in 8: CPU data bus output (write data).
- `read_en` in 1: CPU readNotWrite; 0 = write cycle.
- `dout` out 8: read data; combinational from `addr` and registers.
- `sel` out 1: high when `addr` is in BASE..BASE+6; top muxes `dout` onto dataBusIn.
- `irq` out 1: level interrupt request to core.

## Operation
- Per source: 2-flop synchronizer, then a previous-value flop. Edge = sync & ~prev.
- Edge sets `pending[i]`. A pending bit is set regardless of mask; the mask gates only arbitration and `irq`.
- `active = pending & mask`. `irq = |active`, driven combinationally from flops only.
- Winner selection depends on the configuration (see below). `valid = |active`.
- Register map (offset from BASE):
  - +0 MASK_LO R/W: mask[7:0].
  - +1 MASK_HI R/W: mask[15:8].
  - +2 PEND_LO R: pending[7:0].
  - +3 PEND_HI R: pending[15:8].
  - +4 VECTOR R: {valid, 3'b000, winner[3:0]}, or 8'h00 when not valid. VECTOR W (ack): clears pending[din[3:0]]; ignored if din[3:0] ≥ NUM_SRC.
  - +5 SWSET W: sets pending[din[3:0]] (software trigger); reads 8'h00.
  - +6 CLRALL W: any write clears all pending; reads 8'h00.
- Write qualification: a write happens on every rising edge with `read_en`=0 and a matching `addr`. Reads have no side effects.
- Outside the window: `sel`=0 and `dout`=8'h00.
- Reset values: mask=0 (all masked), pending=0, sync/prev flops=0, rr pointer=0, `irq`=0, `dout`=8'h00 for any non-window address, `sel` depends only on `addr`.
- A source held high through reset release produces one edge after synchronization. This is intended.

## Timing
- `src` rising before clock edge E0 is captured at E0 (sync1) and E1 (sync2). The edge is visible after E1, so `pending` sets at E2 and `irq` rises right after E2. Latency is 3 edges from input to `irq`.
- Mask write takes effect at the write edge; `irq` updates in the same cycle after that edge.
- Ack write at edge E clears the bit at E; `irq` drops after E if nothing else is active.
- Simultaneous set and clear of the same bit in one cycle, from an edge or SWSET versus an ack or CLRALL: set wins, and the bit stays pending.
- Reset asserted mid-operation clears all state immediately (async). `irq` falls without waiting for a clock.

## Configuration
- `IRQC_ROUND_ROBIN_EN` undefined: fixed priority. Lowest active index wins.
- `IRQC_ROUND_ROBIN_EN` defined: rotating priority.
  - 4-bit pointer `rr`. The winner is the first active index at or above `rr`, wrapping modulo NUM_SRC.
  - A valid ack of index k sets `rr` = (k+1) mod NUM_SRC. SWSET and CLRALL do not move `rr`.
- VECTOR format and all timing are identical in both modes.

## Test plan
- Reset, then write MASK_LO=8'h01. Pulse src[0] for 1 cycle -> PEND_LO=8'h01 and `irq`=1 on the 3rd edge. VECTOR reads 8'h80. Write VECTOR din=8'h00 -> `irq`=0 and PEND_LO=8'h00.
- With mask=0, pulse src[3] -> PEND_LO=8'h08 and `irq` stays 0. Write MASK_LO=8'h08 -> `irq`=1 in that cycle, VECTOR=8'h83.
- Fixed priority: mask=16'hFFFF, pend sources 5 and 12 together -> VECTOR=8'h85. Ack 5 -> VECTOR=8'h8C.
- Round robin (macro on): pend 2 and 9, ack 2 -> rr=3. Re-pend 2 -> VECTOR=8'h89. Ack 9 -> rr=10, VECTOR=8'h82.
- Same cycle: src[1] edge arriving at the ack-of-1 write edge -> pending[1] stays 1, `irq` stays 1.
- Write VECTOR din=8'h1F (NUM_SRC=16, index 15 valid) clears bit 15. Write with NUM_SRC=8, din=8'h0A -> no change. Assert `reset` between clocks -> `irq`=0 and all registers read 8'h00.
